spi_master: RTL and testbench

Byte-oriented SPI master, mode 0 (SCLK idles low, MOSI sampled on the rising edge, MISO driven on the falling edge), MSB first. It sits directly upstream of `spi_slave` and drives its `sclk`/`mosi`/`ss` inputs from the system clock. It sends bytes from a valid/ready stream and returns each full-duplex received byte as a one-cycle strobe. Multi-byte transactions keep `ss` low until a byte flagged `tx_last` completes.

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_master_if.sv | 27 ++
 rtl/spi_phase_counter.sv | 28 ++
 rtl/spi_master.sv | 145 ++++++++++++++
 tb/tb_spi_master.sv | 383 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the byte-oriented mode-0 SPI master: FSM states and
// sizing constants.
package spi_pkg;

    localparam int SPI_BITS            = 8;
    localparam int SPI_CLK_DIV_DEFAULT = 4;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        HOLD,
        TEAR,
        GAP
    } spi_state_t;

endpackage

// File: rtl/spi_master_if.sv
// Byte stream plus SPI pin bundle of the SPI master. The master modport is the
// SPI master's own view; the slave modport is the view of whatever drives it.
interface spi_master_if;
    import spi_pkg::*;

    logic                tx_valid;
    logic                tx_ready;
    logic [SPI_BITS-1:0] tx_byte;
    logic                tx_last;
    logic                rx_valid;
    logic [SPI_BITS-1:0] rx_byte;
    logic                sclk;
    logic                mosi;
    logic                miso;
    logic                ss;

    modport master (
        input  tx_valid, tx_byte, tx_last, miso,
        output tx_ready, rx_valid, rx_byte, sclk, mosi, ss
    );

    modport slave (
        output tx_valid, tx_byte, tx_last, miso,
        input  tx_ready, rx_valid, rx_byte, sclk, mosi, ss
    );

endinterface

// File: rtl/spi_phase_counter.sv
// Phase counter for the timed SPI states: counts 0..CLK_DIV-1 and wraps, and
// flags the last cycle of each phase.
module spi_phase_counter #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tc
);
    localparam int             CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0]  LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_reg <= '0;
        end else if (cnt_reg == LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign tc = (cnt_reg == LAST);

endmodule

// File: rtl/spi_master.sv
// Mode-0, MSB-first SPI master fed by a valid/ready byte stream; ss stays low
// across bytes until a byte flagged last has been shifted out.
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = SPI_CLK_DIV_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    spi_master_if.master  bus
);
    localparam logic [3:0] LAST_BIT = 4'(SPI_BITS - 1);
    localparam logic [3:0] ALL_BITS = 4'(SPI_BITS);

    spi_state_t          state_reg;
    logic [SPI_BITS-1:0] shift_reg;
    logic [SPI_BITS-2:0] rx_shift_reg;
    logic [3:0]          bitcnt_reg;
    logic                last_reg;
    logic                tx_ready_reg;
    logic                rx_valid_reg;
    logic [SPI_BITS-1:0] rx_byte_reg;
    logic                sclk_reg;
    logic                ss_reg;
    logic                tc;
    logic                accept;

    // IDLE and HOLD are untimed, so the phase count is parked at zero there.
    spi_phase_counter #(.CLK_DIV(CLK_DIV)) u_phase (
        .clk   (clk),
        .rst   (rst),
        .clear ((state_reg == IDLE) || (state_reg == HOLD)),
        .tc    (tc)
    );

    assign accept = bus.tx_valid && tx_ready_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            shift_reg    <= '0;
            rx_shift_reg <= '0;
            bitcnt_reg   <= '0;
            last_reg     <= 1'b0;
            tx_ready_reg <= 1'b0;
            rx_valid_reg <= 1'b0;
            rx_byte_reg  <= '0;
            sclk_reg     <= 1'b0;
            ss_reg       <= 1'b1;
        end else begin
            rx_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        shift_reg    <= bus.tx_byte;
                        last_reg     <= bus.tx_last;
                        bitcnt_reg   <= '0;
                        tx_ready_reg <= 1'b0;
                        ss_reg       <= 1'b0;
                        state_reg    <= SETUP;
                    end else begin
                        tx_ready_reg <= 1'b1;
                    end
                end
                SETUP: begin
                    if (tc) begin
                        sclk_reg  <= 1'b1;
                        state_reg <= HIGH;
                    end
                end
                HIGH: begin
                    if (tc) begin
                        rx_shift_reg <= {rx_shift_reg[SPI_BITS-3:0], bus.miso};
                        bitcnt_reg   <= bitcnt_reg + 4'd1;
                        sclk_reg     <= 1'b0;
                        state_reg    <= LOW;
                        if (bitcnt_reg == LAST_BIT) begin
                            rx_valid_reg <= 1'b1;
                            rx_byte_reg  <= {rx_shift_reg, bus.miso};
                            tx_ready_reg <= !last_reg;
                        end else begin
                            // Next bit goes out on the falling edge, well before the next rise.
                            shift_reg <= {shift_reg[SPI_BITS-2:0], 1'b0};
                        end
                    end
                end
                LOW: begin
                    if (accept) begin
                        shift_reg    <= bus.tx_byte;
                        last_reg     <= bus.tx_last;
                        bitcnt_reg   <= '0;
                        tx_ready_reg <= 1'b0;
                    end
                    if (tc) begin
                        if (accept || (bitcnt_reg != ALL_BITS)) begin
                            sclk_reg     <= 1'b1;
                            tx_ready_reg <= 1'b0;
                            state_reg    <= HIGH;
                        end else if (last_reg) begin
                            // Clearing the shifter forces mosi low for the rest of the frame.
                            shift_reg    <= '0;
                            tx_ready_reg <= 1'b0;
                            state_reg    <= TEAR;
                        end else begin
                            tx_ready_reg <= 1'b1;
                            state_reg    <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (accept) begin
                        shift_reg    <= bus.tx_byte;
                        last_reg     <= bus.tx_last;
                        bitcnt_reg   <= '0;
                        tx_ready_reg <= 1'b0;
                        state_reg    <= SETUP;
                    end
                end
                TEAR: begin
                    if (tc) begin
                        ss_reg    <= 1'b1;
                        state_reg <= GAP;
                    end
                end
                GAP: begin
                    if (tc) begin
                        tx_ready_reg <= 1'b1;
                        state_reg    <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx_ready = tx_ready_reg;
    assign bus.rx_valid = rx_valid_reg;
    assign bus.rx_byte  = rx_byte_reg;
    assign bus.sclk     = sclk_reg;
    assign bus.mosi     = shift_reg[SPI_BITS-1];
    assign bus.ss       = ss_reg;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: a timing model built from the cycle formulas of a
// transaction, a mode-0 slave model, and directed scenarios with literal checks.
module tb_spi_master;
    import spi_pkg::*;

    localparam int D  = 4;
    localparam int D1 = 2;
    localparam int S_BURST = 0;
    localparam int S_HOLD  = 1;
    localparam int S_RST   = 2;
    localparam int S_GAP   = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_master_if bus0();
    spi_master_if bus1();

    spi_master #(.CLK_DIV(D)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.master)
    );

    spi_master #(.CLK_DIV(D1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.master)
    );

    assign bus1.miso = bus1.mosi;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scenario selection for the timing model.
    int scen = S_BURST;
    int nb   = 1;
    int pp   = 0;
    int t0   = 0;
    bit cmp_en = 1'b0;

    logic [7:0] exp_tx_q[$];
    logic [7:0] resp_q[$];
    logic [7:0] rx_exp_q[$];

    int         rxv_t[$];
    logic [7:0] rxb[$];
    int         rise_t[$];
    int         acc_t[$];
    int         ss_fall_t = -1;
    int         ss_rise_t = -1;
    logic [7:0] last_mosi_byte = 8'h00;

    // {tx_ready, ss, sclk, rx_valid} for a run of n back-to-back bytes accepted at t=0.
    function automatic logic [3:0] burst_vec(int t, int n, int d);
        logic rdy, ss, sclk, rxv;
        int k;
        ss   = !(t >= 1 && t <= (16 * n + 2) * d);
        sclk = (t >= 1 && t <= 16 * n * d && (((t - 1) / d) % 2) == 1);
        k    = (t - 1) / (16 * d);
        rxv  = (t >= 1 && ((t - 1) % (16 * d)) == 0 && k >= 1 && k <= n);
        rdy  = (t <= 0) || (t >= (16 * n + 3) * d + 1) || (rxv && k < n);
        return {rdy, ss, sclk, rxv};
    endfunction

    function automatic logic [3:0] model(int s, int t, int n, int d, int p);
        logic [3:0] v;
        v = burst_vec(t, n, d);
        case (s)
            S_HOLD: begin
                if (t > 16 * d && t <= p)
                    v = {1'b1, 1'b0, 1'b0, (t == 16 * d + 1)};
                else if (t > p)
                    v = burst_vec(t - p, 1, d);
            end
            S_RST: begin
                if (t == p + 1)
                    v = 4'b0100;
                else if (t > p + 1)
                    v = 4'b1100;
            end
            S_GAP: begin
                if (t >= p)
                    v = burst_vec(t - p, 1, d);
            end
            default: ;
        endcase
        return v;
    endfunction

    function automatic int qget(int q[$], int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic chk(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Per-cycle comparison against the timing model, plus event recording.
    int         t_cmp;
    logic [3:0] e_cmp, a_cmp;
    logic [7:0] x_cmp;
    logic       prev_sclk0 = 1'b0;
    logic       prev_ss0   = 1'b1;
    always @(negedge clk) begin
        if (cmp_en) begin
            t_cmp = cyc - t0;
            e_cmp = model(scen, t_cmp, nb, D, pp);
            a_cmp = {bus0.tx_ready, bus0.ss, bus0.sclk, bus0.rx_valid};
            checks++;
            if (a_cmp !== e_cmp) begin
                errors++;
                $display("FAIL timing t=%0d: {rdy,ss,sclk,rxv} got %b, want %b", t_cmp, a_cmp, e_cmp);
            end
            if (e_cmp[2]) begin
                checks++;
                if (bus0.mosi !== 1'b0) begin
                    errors++;
                    $display("FAIL mosi_idle t=%0d: got %b, want 0", t_cmp, bus0.mosi);
                end
            end
            if (bus0.rx_valid === 1'b1) begin
                rxv_t.push_back(t_cmp);
                rxb.push_back(bus0.rx_byte);
                checks++;
                if (rx_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rx_byte t=%0d: got %h, want no strobe", t_cmp, bus0.rx_byte);
                end else begin
                    x_cmp = rx_exp_q.pop_front();
                    if (bus0.rx_byte !== x_cmp) begin
                        errors++;
                        $display("FAIL rx_byte t=%0d: got %h, want %h", t_cmp, bus0.rx_byte, x_cmp);
                    end
                end
            end
            if (bus0.sclk && !prev_sclk0) rise_t.push_back(t_cmp);
            if (!bus0.ss && prev_ss0 && ss_fall_t < 0) ss_fall_t = t_cmp;
            if (bus0.ss && !prev_ss0 && ss_rise_t < 0) ss_rise_t = t_cmp;
            if (bus0.tx_valid && bus0.tx_ready) acc_t.push_back(t_cmp);
        end
        prev_sclk0 = bus0.sclk;
        prev_ss0   = bus0.ss;
    end

    // Mode-0 slave: captures mosi on sclk rise, changes miso after sclk fall.
    logic [7:0] cur = 8'h00;
    logic [7:0] got = 8'h00;
    int         sb = 0;
    logic       ps_sclk = 1'b0;
    logic       ps_ss = 1'b1;
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            sb = 0;
            got = 8'h00;
            bus0.miso = 1'b0;
        end else begin
            if (!bus0.ss && ps_ss) begin
                sb = 0;
                if (resp_q.size() > 0) cur = resp_q.pop_front();
                bus0.miso = cur[7];
            end
            if (bus0.sclk && !ps_sclk) begin
                got = {got[6:0], bus0.mosi};
                sb++;
                if (sb == 8) begin
                    checks++;
                    if (exp_tx_q.size() == 0) begin
                        errors++;
                        $display("FAIL mosi_byte: got %h, want no byte", got);
                    end else begin
                        if (got !== exp_tx_q[0]) begin
                            errors++;
                            $display("FAIL mosi_byte: got %h, want %h", got, exp_tx_q[0]);
                        end
                        void'(exp_tx_q.pop_front());
                    end
                    rx_exp_q.push_back(cur);
                    last_mosi_byte = got;
                    sb = 0;
                end
            end else if (!bus0.sclk && ps_sclk) begin
                if (sb == 0 && resp_q.size() > 0) cur = resp_q.pop_front();
                bus0.miso = cur[3'(7 - sb)];
            end
        end
        ps_sclk = bus0.sclk;
        ps_ss   = bus0.ss;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_t(int t);
        while (cyc < t0 + t) tick();
    endtask

    task automatic begin_scen(int s, int n, int p);
        tick();
        rxv_t.delete();
        rxb.delete();
        rise_t.delete();
        acc_t.delete();
        ss_fall_t = -1;
        ss_rise_t = -1;
        scen = s;
        nb = n;
        pp = p;
        t0 = cyc;
        cmp_en = 1'b1;
    endtask

    task automatic end_scen(int t_end);
        goto_t(t_end);
        cmp_en = 1'b0;
    endtask

    task automatic drive(logic [7:0] b, logic l);
        bus0.tx_valid = 1'b1;
        bus0.tx_byte  = b;
        bus0.tx_last  = l;
        exp_tx_q.push_back(b);
    endtask

    int         t1;
    int         rx1_t;
    logic [7:0] rx1_b;
    int         r1[$];
    logic       ps1;

    initial begin
        rst = 1'b1;
        bus0.tx_valid = 1'b0; bus0.tx_byte = 8'h00; bus0.tx_last = 1'b0;
        bus1.tx_valid = 1'b0; bus1.tx_byte = 8'h00; bus1.tx_last = 1'b0;
        tick();
        tick();
        chk("reset_ss", int'(bus0.ss), 1);
        chk("reset_sclk", int'(bus0.sclk), 0);
        chk("reset_mosi", int'(bus0.mosi), 0);
        chk("reset_tx_ready", int'(bus0.tx_ready), 0);
        chk("reset_rx_valid", int'(bus0.rx_valid), 0);
        chk("reset_rx_byte", int'(bus0.rx_byte), 0);
        rst = 1'b0;
        repeat (3) tick();
        chk("idle_tx_ready", int'(bus0.tx_ready), 1);

        // Single byte 0xA5, slave answers 0x3C.
        resp_q.push_back(8'h3C);
        begin_scen(S_BURST, 1, 0);
        drive(8'hA5, 1'b1);
        goto_t(1);
        bus0.tx_valid = 1'b0;
        end_scen(80);
        chk("single_mosi_byte", int'(last_mosi_byte), 'hA5);
        chk("single_rx_count", rxv_t.size(), 1);
        chk("single_rx_time", qget(rxv_t, 0), 65);
        chk("single_rx_byte", (rxb.size() > 0) ? int'(rxb[0]) : -1, 'h3C);
        chk("single_ss_fall", ss_fall_t, 1);
        chk("single_ss_rise", ss_rise_t, 73);
        chk("single_first_rise", qget(rise_t, 0), 5);

        // Burst 0x01, 0x80, 0xFF(last) with tx_valid held.
        resp_q.push_back(8'h11); resp_q.push_back(8'h22); resp_q.push_back(8'h33);
        begin_scen(S_BURST, 3, 0);
        drive(8'h01, 1'b0);
        goto_t(1);
        drive(8'h80, 1'b0);
        goto_t(66);
        drive(8'hFF, 1'b1);
        goto_t(130);
        bus0.tx_valid = 1'b0;
        end_scen(207);
        chk("burst_rx0_time", qget(rxv_t, 0), 65);
        chk("burst_rx1_time", qget(rxv_t, 1), 129);
        chk("burst_rx2_time", qget(rxv_t, 2), 193);
        chk("burst_sclk_rises", rise_t.size(), 24);
        chk("burst_last_rise", qget(rise_t, 23), 189);
        chk("burst_ss_rise", ss_rise_t, 201);

        // First byte not last; second byte 100 cycles after the first strobe.
        resp_q.push_back(8'h5C); resp_q.push_back(8'hC5);
        begin_scen(S_HOLD, 1, 165);
        drive(8'h96, 1'b0);
        goto_t(1);
        bus0.tx_valid = 1'b0;
        goto_t(165);
        drive(8'h69, 1'b1);
        goto_t(166);
        bus0.tx_valid = 1'b0;
        end_scen(243);
        chk("hold_rises", rise_t.size(), 16);
        chk("hold_resume_rise", qget(rise_t, 8), 170);
        chk("hold_rx1_time", qget(rxv_t, 1), 230);
        chk("hold_ss_rise", ss_rise_t, 238);

        // Reset asserted during the HIGH phase of bit 3.
        resp_q.push_back(8'hAA);
        begin_scen(S_RST, 1, 22);
        drive(8'hC3, 1'b1);
        goto_t(1);
        bus0.tx_valid = 1'b0;
        goto_t(22);
        rst = 1'b1;
        goto_t(23);
        rst = 1'b0;
        exp_tx_q.delete();
        resp_q.delete();
        rx_exp_q.delete();
        chk("rst_mid_ss", int'(bus0.ss), 1);
        chk("rst_mid_sclk", int'(bus0.sclk), 0);
        chk("rst_mid_mosi", int'(bus0.mosi), 0);
        chk("rst_mid_rx_valid", int'(bus0.rx_valid), 0);
        end_scen(40);
        chk("rst_no_rx", rxv_t.size(), 0);

        resp_q.push_back(8'h81);
        begin_scen(S_BURST, 1, 0);
        drive(8'h3E, 1'b1);
        goto_t(1);
        bus0.tx_valid = 1'b0;
        end_scen(80);
        chk("post_rst_rx_time", qget(rxv_t, 0), 65);
        chk("post_rst_rx_byte", (rxb.size() > 0) ? int'(rxb[0]) : -1, 'h81);

        // tx_valid raised during GAP must wait for IDLE.
        resp_q.push_back(8'h0F);
        begin_scen(S_GAP, 1, 77);
        drive(8'hF0, 1'b1);
        goto_t(1);
        bus0.tx_valid = 1'b0;
        goto_t(74);
        resp_q.push_back(8'hE1);
        drive(8'h1E, 1'b1);
        goto_t(78);
        bus0.tx_valid = 1'b0;
        end_scen(157);
        chk("gap_accepts", acc_t.size(), 2);
        chk("gap_ss_rise", ss_rise_t, 73);
        chk("gap_accept_time", qget(acc_t, 1), 77);
        chk("gap_ss_high_to_accept", qget(acc_t, 1) - ss_rise_t, D);

        // CLK_DIV=2 loopback of 0x5A.
        tick();
        t1 = cyc;
        bus1.tx_valid = 1'b1;
        bus1.tx_byte  = 8'h5A;
        bus1.tx_last  = 1'b1;
        tick();
        bus1.tx_valid = 1'b0;
        rx1_t = -1;
        rx1_b = 8'h00;
        ps1 = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus1.sclk && !ps1) r1.push_back(cyc - t1);
            ps1 = bus1.sclk;
            if (bus1.rx_valid && rx1_t < 0) begin
                rx1_t = cyc - t1;
                rx1_b = bus1.rx_byte;
            end
        end
        chk("lb_rx_seen", int'(rx1_t >= 0), 1);
        chk("lb_rx_byte", int'(rx1_b), 'h5A);
        chk("lb_rx_time", rx1_t, 33);
        chk("lb_rises", r1.size(), 8);
        chk("lb_first_rise", qget(r1, 0), 3);
        chk("lb_sclk_period", qget(r1, 1) - qget(r1, 0), 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
